// File: rtl/fetch_stage_pkg.sv
// Shared constants and types for the LEGv8 instruction-fetch stage.
package fetch_stage_pkg;

    localparam int WORDSIZE_DEF    = 64;
    localparam int INSTRSIZE_DEF   = 32;
    localparam int COUNTERSIZE_DEF = 3;
    localparam int PC_INCR         = 4;

    localparam logic [INSTRSIZE_DEF-1:0] BUBBLE_INSTR = 32'h0;

    // The fill counter only distinguishes "still counting" from "saturated".
    typedef enum logic {
        MODE_RUN    = 1'b0,
        MODE_FILLED = 1'b1
    } fill_mode_e;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: hazard/redirect inputs, instruction memory port and IF/ID outputs.
interface fetch_stage_if
    import fetch_stage_pkg::*;
#(
    parameter int WORDSIZE    = WORDSIZE_DEF,
    parameter int INSTRSIZE   = INSTRSIZE_DEF,
    parameter int COUNTERSIZE = COUNTERSIZE_DEF
);
    logic                   stall;
    logic                   branch_taken;
    logic [WORDSIZE-1:0]    branch_target;
    logic [INSTRSIZE-1:0]   imem_data;
    logic [WORDSIZE-1:0]    imem_addr;
    logic [WORDSIZE-1:0]    ifid_pc;
    logic [INSTRSIZE-1:0]   ifid_instr;
    logic                   ifid_valid;
    logic [COUNTERSIZE-1:0] stage;

    modport slave (
        input  stall, branch_taken, branch_target, imem_data,
        output imem_addr, ifid_pc, ifid_instr, ifid_valid, stage
    );

    modport master (
        output stall, branch_taken, branch_target, imem_data,
        input  imem_addr, ifid_pc, ifid_instr, ifid_valid, stage
    );

endinterface

// File: rtl/fetch_stage_pc_reg.sv
// Program counter: sequential +4, word-aligned branch redirect, stall hold.
module fetch_stage_pc_reg
    import fetch_stage_pkg::*;
#(
    parameter int                  WORDSIZE = WORDSIZE_DEF,
    parameter logic [WORDSIZE-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall,
    input  logic                branch_taken,
    input  logic [WORDSIZE-1:0] branch_target,
    output logic [WORDSIZE-1:0] pc
);

    localparam logic [WORDSIZE-1:0] INCR = WORDSIZE'(PC_INCR);

    logic [WORDSIZE-1:0] pc_p0;

    // Redirect outranks stall: the stalled instruction is on the wrong path.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_p0 <= RESET_PC;
        end else if (branch_taken) begin
            pc_p0 <= {branch_target[WORDSIZE-1:2], 2'b00};
        end else if (!stall) begin
            pc_p0 <= pc_p0 + INCR;
        end
    end

    assign pc = pc_p0;

endmodule

// File: rtl/fetch_stage.sv
// LEGv8 instruction fetch: PC sequencing, IF/ID pipeline register, fill counter.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int                  WORDSIZE    = WORDSIZE_DEF,
    parameter int                  INSTRSIZE   = INSTRSIZE_DEF,
    parameter int                  COUNTERSIZE = COUNTERSIZE_DEF,
    parameter logic [WORDSIZE-1:0] RESET_PC    = '0
) (
    input  logic          clk,
    input  logic          reset,
    fetch_stage_if.slave  bus
);

    localparam logic [COUNTERSIZE-1:0] STAGE_MAX = '1;

    logic [WORDSIZE-1:0]    pc_p0;
    logic [WORDSIZE-1:0]    ifid_pc_p1;
    logic [INSTRSIZE-1:0]   ifid_instr_p1;
    logic                   vld_p1;
    logic [COUNTERSIZE-1:0] stage_q;
    fill_mode_e             mode_q;

    fetch_stage_pc_reg #(
        .WORDSIZE (WORDSIZE),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk           (clk),
        .reset         (reset),
        .stall         (bus.stall),
        .branch_taken  (bus.branch_taken),
        .branch_target (bus.branch_target),
        .pc            (pc_p0)
    );

    assign bus.imem_addr = pc_p0;

    // IF -> ID boundary
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ifid_pc_p1    <= '0;
            ifid_instr_p1 <= INSTRSIZE'(BUBBLE_INSTR);
            vld_p1        <= 1'b0;
        end else if (bus.branch_taken) begin
            ifid_pc_p1    <= '0;
            ifid_instr_p1 <= INSTRSIZE'(BUBBLE_INSTR);
            vld_p1        <= 1'b0;
        end else if (!bus.stall) begin
            ifid_pc_p1    <= pc_p0;
            ifid_instr_p1 <= bus.imem_data;
            vld_p1        <= 1'b1;
        end
    end

    // Fill counter runs free of stall/redirect and parks at its maximum.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage_q <= '0;
            mode_q  <= MODE_RUN;
        end else if (mode_q == MODE_RUN) begin
            stage_q <= stage_q + COUNTERSIZE'(1);
            if (stage_q == STAGE_MAX - COUNTERSIZE'(1)) begin
                mode_q <= MODE_FILLED;
            end
        end
    end

    assign bus.ifid_pc    = ifid_pc_p1;
    assign bus.ifid_instr = ifid_instr_p1;
    assign bus.ifid_valid = vld_p1;
    assign bus.stage      = stage_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: model predicts post-edge state, queue holds it until sampled.
module tb_fetch_stage;

    logic clk;
    logic reset;

    fetch_stage_if bus ();

    fetch_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] imem_word(input logic [63:0] a);
        return 32'h8B02_0020 + (a[31:0] >> 2) * 32'h0001_0021;
    endfunction

    assign bus.imem_data = imem_word(bus.imem_addr);

    typedef struct {
        logic [63:0] pc;
        logic [63:0] ifid_pc;
        logic [31:0] instr;
        logic        valid;
        logic [2:0]  stage;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] m_pc;
    logic [63:0] m_ifid_pc;
    logic [31:0] m_instr;
    logic        m_valid;
    logic [2:0]  m_stage;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pc      = 64'h0;
        m_ifid_pc = 64'h0;
        m_instr   = 32'h0;
        m_valid   = 1'b0;
        m_stage   = 3'd0;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_addr"},  bus.imem_addr,  64'h0);
        check({tag, "_pc"},    bus.ifid_pc,    64'h0);
        check({tag, "_instr"}, {32'h0, bus.ifid_instr}, 64'h0);
        check({tag, "_valid"}, {63'h0, bus.ifid_valid}, 64'h0);
        check({tag, "_stage"}, {61'h0, bus.stage}, 64'h0);
    endtask

    // Entered and left on a falling edge.
    task automatic step(input logic st, input logic br, input logic [63:0] tgt, input string tag);
        exp_t e;
        exp_t got;
        bus.stall         = st;
        bus.branch_taken  = br;
        bus.branch_target = tgt;
        check({tag, "_addr_pre"}, bus.imem_addr, m_pc);
        if (br) begin
            m_ifid_pc = 64'h0;
            m_instr   = 32'h0;
            m_valid   = 1'b0;
            m_pc      = {tgt[63:2], 2'b00};
        end else if (!st) begin
            m_ifid_pc = m_pc;
            m_instr   = imem_word(m_pc);
            m_valid   = 1'b1;
            m_pc      = m_pc + 64'd4;
        end
        if (m_stage != 3'd7) m_stage = m_stage + 3'd1;
        e.pc = m_pc; e.ifid_pc = m_ifid_pc; e.instr = m_instr;
        e.valid = m_valid; e.stage = m_stage;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL %s_sb: got empty queue expected entry", tag);
        end else begin
            got = sb.pop_front();
            check({tag, "_addr"},  bus.imem_addr, got.pc);
            check({tag, "_ifpc"},  bus.ifid_pc, got.ifid_pc);
            check({tag, "_instr"}, {32'h0, bus.ifid_instr}, {32'h0, got.instr});
            check({tag, "_valid"}, {63'h0, bus.ifid_valid}, {63'h0, got.valid});
            check({tag, "_stage"}, {61'h0, bus.stage}, {61'h0, got.stage});
        end
        @(negedge clk);
    endtask

    initial begin
        reset             = 1'b1;
        bus.stall         = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.branch_target = 64'h0;
        model_reset();
        repeat (2) @(negedge clk);
        check_cleared("reset");
        reset = 1'b0;

        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 64'h0, "seq");
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 64'h0, "stall");
        step(1'b0, 1'b0, 64'h0, "unstall");

        step(1'b0, 1'b1, 64'h0000_0000_0000_0103, "redir");
        step(1'b0, 1'b0, 64'h0, "after_redir");
        step(1'b1, 1'b1, 64'h0000_0000_0000_0200, "stall_redir");
        step(1'b0, 1'b0, 64'h0, "after_sr");

        step(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, "to_top");
        step(1'b0, 1'b0, 64'h0, "wrap");
        step(1'b0, 1'b0, 64'h0, "post_wrap");

        // Asynchronous reset in the low phase, checked before the next edge.
        #2 reset = 1'b1;
        #1 check_cleared("async_rst");
        @(negedge clk);
        check_cleared("rst_held");
        reset = 1'b0;
        model_reset();

        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 64'h0, "sat");

        for (int i = 0; i < 40; i++) begin
            logic        st;
            logic        br;
            logic [63:0] tgt;
            st  = ($urandom_range(0, 3) == 0);
            br  = ($urandom_range(0, 5) == 0);
            tgt = {$urandom, $urandom};
            step(st, br, tgt, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
